// File: rtl/pipeline_unload_pkg.sv
// Shared definitions for the pipeline_unload slice: port-word layout,
// direction indices, group packing and the unload FSM state type.
package pipeline_unload_pkg;

  localparam int FLIT_W  = 7;
  localparam int NUM_DIR = 4;
  localparam int WORD_W  = 10;
  localparam int GRP_W   = NUM_DIR * FLIT_W;

  localparam int VLD_BIT = 9;
  localparam int RSV_HI  = 8;
  localparam int RSV_LO  = 6;
  localparam int DATA_HI = 5;
  localparam int DATA_LO = 0;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // Returns {found, index} of the lowest set bit of a slot mask.
  function automatic logic [2:0] first_set(input logic [NUM_DIR-1:0] m);
    first_set = 3'b000;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (m[i]) first_set = {1'b1, 2'(i)};
    end
  endfunction

endpackage

// File: rtl/pipeline_unload_group_fifo.sv
// Generic register FIFO of flit groups; exposes the head entry and the entry
// behind it so the unloader can chain groups without a bubble.
module unload_group_fifo #(
  parameter int GROUP_DEPTH = 5,
  parameter int DATA_W      = 28
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic                               pop,
  output logic [DATA_W-1:0]                  head,
  output logic [DATA_W-1:0]                  head_nxt,
  output logic [$clog2(GROUP_DEPTH+1)-1:0]   count,
  output logic                               empty
);

  localparam int PTR_W = $clog2(GROUP_DEPTH);
  localparam int CNT_W = $clog2(GROUP_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [GROUP_DEPTH];
  logic [DATA_W-1:0] mem_d [GROUP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(GROUP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign head_nxt = mem_q[ptr_inc(rd_ptr_q)];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/pipeline_unload.sv
// Buffers N/S/E/W flit groups and replays them as a serial, direction-tagged
// flit stream. Define UNLOAD_SKIP_EMPTY_EN to suppress zero-payload slots.
module pipeline_unload
  import pipeline_unload_pkg::*;
#(
  parameter int GROUP_DEPTH = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WORD_W-1:0]                nin,
  input  logic [WORD_W-1:0]                sin,
  input  logic [WORD_W-1:0]                ein,
  input  logic [WORD_W-1:0]                win,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [FLIT_W-1:0]                outc,
  output logic                             nsig,
  output logic                             ssig,
  output logic                             esig,
  output logic                             wsig,
  input  logic                             out_ready,
  output logic [$clog2(GROUP_DEPTH+1)-1:0] grp_count
);

  localparam int CNT_W = $clog2(GROUP_DEPTH + 1);

  logic [GRP_W-1:0]   wdata, head, head_nxt;
  logic [CNT_W-1:0]   count;
  logic               empty, push, pop;
  logic               unused_rsv;

  state_e             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [FLIT_W-1:0]  outc_q, outc_d;
  logic [NUM_DIR-1:0] sig_q, sig_d;

  logic [NUM_DIR-1:0] head_mask, next_mask, above;
  logic [2:0]         head_first, next_first, adv;

  // Slot 0 (north) sits in the low bits of a FIFO entry.
  assign wdata = {win[VLD_BIT], win[DATA_HI:DATA_LO],
                  ein[VLD_BIT], ein[DATA_HI:DATA_LO],
                  sin[VLD_BIT], sin[DATA_HI:DATA_LO],
                  nin[VLD_BIT], nin[DATA_HI:DATA_LO]};
  assign unused_rsv = ^{nin[RSV_HI:RSV_LO], sin[RSV_HI:RSV_LO],
                        ein[RSV_HI:RSV_LO], win[RSV_HI:RSV_LO]};

  assign in_ready = rst_n && (count < CNT_W'(GROUP_DEPTH));
  assign push     = in_valid && in_ready;

  unload_group_fifo #(
    .GROUP_DEPTH (GROUP_DEPTH),
    .DATA_W      (GRP_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    (wdata),
    .pop      (pop),
    .head     (head),
    .head_nxt (head_nxt),
    .count    (count),
    .empty    (empty)
  );

  // Masks mark which slots are presented; "last" is simply the top set bit.
  always_comb begin
    head_mask = '0;
    next_mask = '0;
    above     = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
`ifdef UNLOAD_SKIP_EMPTY_EN
      head_mask[i] = |head[i*FLIT_W +: FLIT_W];
      next_mask[i] = |head_nxt[i*FLIT_W +: FLIT_W];
`else
      head_mask[i] = 1'b1;
      next_mask[i] = 1'b1;
`endif
      above[i] = head_mask[i] && (i > int'(slot_q));
    end
    head_first = first_set(head_mask);
    next_first = first_set(next_mask);
    adv        = first_set(above);
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    outc_d  = outc_q;
    sig_d   = sig_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head_first[2]) begin
            state_d = ST_SEND;
            slot_d  = head_first[1:0];
            outc_d  = head[head_first[1:0]*FLIT_W +: FLIT_W];
            sig_d   = NUM_DIR'(1) << head_first[1:0];
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (adv[2]) begin
            slot_d = adv[1:0];
            outc_d = head[adv[1:0]*FLIT_W +: FLIT_W];
            sig_d  = NUM_DIR'(1) << adv[1:0];
          end else begin
            pop = 1'b1;
            // Chain straight into the next buffered group to avoid a bubble.
            if (count > CNT_W'(1) && next_first[2]) begin
              slot_d = next_first[1:0];
              outc_d = head_nxt[next_first[1:0]*FLIT_W +: FLIT_W];
              sig_d  = NUM_DIR'(1) << next_first[1:0];
            end else begin
              state_d = ST_IDLE;
              slot_d  = '0;
              outc_d  = '0;
              sig_d   = '0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      outc_q  <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      outc_q  <= outc_d;
      sig_q   <= sig_d;
    end
  end

  assign outc      = outc_q;
  assign nsig      = sig_q[DIR_N];
  assign ssig      = sig_q[DIR_S];
  assign esig      = sig_q[DIR_E];
  assign wsig      = sig_q[DIR_W];
  assign grp_count = count;

endmodule

// File: doc/pipeline_unload.md
Name: pipeline_unload

Overview:
- Return-direction counterpart of the router's input pipeline stage.
- Each accepted cycle captures one 4-flit group: the N/S/E/W 10-bit port words.
- Extracts the 7-bit flit payload from each word and buffers groups in a FIFO.
- Replays them as a serial flit stream, one flit per handshake, each tagged with a one-hot direction strobe (N, S, E, W order); feeds the local ejection/injection side.

Parameters:
- GROUP_DEPTH, 5, number of 4-flit groups buffered (5 groups = 20 flits); must be ≥2.
- FLIT_W, 7, payload width; fixed at 7 by the port-word packing.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- nin  in  10  north port word; payload = {nin[9], nin[5:0]}; bits [8:6] ignored.
- sin  in  10  south port word, same packing.
- ein  in  10  east port word, same packing.
- win  in  10  west port word, same packing.
- in_valid  in  1  group present on nin/sin/ein/win this cycle.
- in_ready  out  1  FIFO can accept a group.
- outc  out  7  flit payload being presented.
- nsig, ssig, esig, wsig  out  1 each  one-hot direction tag of outc; all low = no flit.
- out_ready  in  1  downstream consumes the presented flit this cycle.
- grp_count  out  $clog2(GROUP_DEPTH+1)  groups held, including the group being drained.

Behaviour:
- Reset (async assert, sync release): FIFO pointers, grp_count, outc = 0; all sigs = 0; state IDLE.
  - in_ready = 0 while rst_n low.
  - Reset mid-drain discards all buffered flits, with no partial output.
- Push:
  - Occurs on a clk edge with in_valid && in_ready.
  - Writes the 4 payloads (N, S, E, W) into one FIFO entry.
  - in_ready = (grp_count < GROUP_DEPTH), combinational from registered count.
  - A same-cycle pop does not raise in_ready when full.
  - in_valid while in_ready = 0: group dropped; no state change.
- FSM states:
  - IDLE: no flit presented. If grp_count > 0, load head group slot 0 into the output registers and go to SEND.
  - SEND(slot): outc/sig registered and held stable while out_ready = 0.
    - out_ready && slot < last: advance slot.
    - out_ready && slot == last: pop the head group. If another group is already buffered, present its slot 0 on the next cycle with no bubble; otherwise go to IDLE.
- Latency:
  - A group pushed at edge k into an empty block shows its N flit after edge k+1.
  - Four flits take a minimum of 4 cycles.
  - Sustained throughput: 1 flit/cycle.
- Simultaneous push and pop: grp_count unchanged; both pointers advance.
- Pointer wrap: modulo GROUP_DEPTH; count distinguishes full from empty.
- Exactly one sig is high in SEND; all sigs are low in IDLE.

Optional Feature:
- Macro UNLOAD_SKIP_EMPTY_EN.
- Defined:
  - Slots whose 7-bit payload == 0 are not presented.
  - "last" is the highest non-zero slot; a group with all payloads zero is popped in one cycle with no output.
  - A push of an all-zero group is still accepted and counted.
- Undefined: all four slots are always presented; last = 3.

Decomposition:
- Shared package: FLIT_W; port-word field positions (valid bit 9, reserved [8:6], data [5:0]); direction index constants DIR_N=0 … DIR_W=3; FSM state enum.
- Sub-module: unload_group_fifo. Generic GROUP_DEPTH × (4×FLIT_W) register FIFO with push/pop/count. pipeline_unload holds the FSM and output registers.

Test Plan:
- Reset then single group: nin=10'h201, sin=10'h002, ein=10'h203, win=10'h004, out_ready=1.
  - Expect outc=7'h41/nsig, 7'h02/ssig, 7'h43/esig, 7'h04/wsig on 4 consecutive cycles, then all sigs low.
- Back-to-back groups with out_ready=1: 3 groups pushed on consecutive cycles.
  - Expect 12 flits contiguous, no idle cycle; grp_count peaks at 3, returns to 0.
- Fill:
  - out_ready=0; push 6 groups with GROUP_DEPTH=5.
  - Expect in_ready low after 5th; 6th dropped; nsig held with stable outc.
  - Release out_ready: exactly 20 flits appear.
- Async reset asserted mid-group at the E slot.
  - Expect immediate outputs 0, grp_count 0, in_ready 0.
  - After release, a new group drains from N correctly.
- UNLOAD_SKIP_EMPTY_EN defined: group with sin=ein=0.
  - Expect only N then W flits.
  - An all-zero group produces no sigs and grp_count decrements.
  - Undefined: zero flits are presented with ssig/esig.
